// File: rtl/ln_norm_sequencer.sv
// Per-sample sequencer for the linearize/normalize datapath: clear, launch,
// collect both ACKs (with timeout guard), then hold the result pair on valid/ready.
module ln_norm_sequencer #(
   parameter int P          = 32,
   parameter int CLR_CYCLES = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic [P-1:0] I_IN,
   input  logic [P-1:0] V_IN,
   output logic [P-1:0] I,
   output logic [P-1:0] V,
   output logic         RST_LN_FF,
   output logic         Begin_FSM_I,
   output logic         Begin_FSM_V,
   input  logic         ACK_I,
   input  logic         ACK_V,
   input  logic         O_F,
   input  logic         U_F,
   input  logic [P-1:0] RESULT_I,
   input  logic [P-1:0] RESULT_V,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [P-1:0] OUT_I,
   output logic [P-1:0] OUT_V,
   output logic         OUT_OF,
   output logic         OUT_UF,
   output logic         OUT_TO
);

   localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {IDLE, CLR, START, WAIT, DONE} state_t;

   state_t        state;
   logic [CW-1:0] clr_cnt;
   logic [TW-1:0] tcnt;
   logic          i_seen;
   logic          v_seen;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state       <= IDLE;
         clr_cnt     <= '0;
         tcnt        <= '0;
         i_seen      <= 1'b0;
         v_seen      <= 1'b0;
         IN_READY    <= 1'b0;
         RST_LN_FF   <= 1'b1;
         Begin_FSM_I <= 1'b0;
         Begin_FSM_V <= 1'b0;
         OUT_VALID   <= 1'b0;
         I           <= '0;
         V           <= '0;
         OUT_I       <= '0;
         OUT_V       <= '0;
         OUT_OF      <= 1'b0;
         OUT_UF      <= 1'b0;
         OUT_TO      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               IN_READY  <= 1'b1;
               RST_LN_FF <= 1'b0;
               // per-conversion state is cleared here, on the transition into CLR
               if (IN_READY && IN_VALID) begin
                  I         <= I_IN;
                  V         <= V_IN;
                  IN_READY  <= 1'b0;
                  RST_LN_FF <= 1'b1;
                  clr_cnt   <= '0;
                  tcnt      <= '0;
                  i_seen    <= 1'b0;
                  v_seen    <= 1'b0;
                  OUT_OF    <= 1'b0;
                  OUT_UF    <= 1'b0;
                  OUT_TO    <= 1'b0;
                  state     <= CLR;
               end
            end
            CLR: begin
               if (clr_cnt == CW'(CLR_CYCLES - 1)) begin
                  RST_LN_FF   <= 1'b0;
                  Begin_FSM_I <= 1'b1;
                  Begin_FSM_V <= 1'b1;
                  state       <= START;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            START: begin
               Begin_FSM_I <= 1'b0;
               Begin_FSM_V <= 1'b0;
               state       <= WAIT;
            end
            WAIT: begin
               if (ACK_I && !i_seen) begin
                  OUT_I  <= RESULT_I;
                  i_seen <= 1'b1;
               end
               if (ACK_V && !v_seen) begin
                  OUT_V  <= RESULT_V;
                  v_seen <= 1'b1;
               end
               OUT_OF <= OUT_OF | O_F;
               OUT_UF <= OUT_UF | U_F;
               if ((i_seen || ACK_I) && (v_seen || ACK_V)) begin
                  OUT_VALID <= 1'b1;
                  state     <= DONE;
               end else if (tcnt == TW'(TIMEOUT - 1)) begin
                  OUT_VALID <= 1'b1;
                  OUT_TO    <= 1'b1;
                  if (!(i_seen || ACK_I)) OUT_I <= '0;
                  if (!(v_seen || ACK_V)) OUT_V <= '0;
                  state     <= DONE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            DONE: begin
               if (OUT_READY) begin
                  OUT_VALID <= 1'b0;
                  IN_READY  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
